// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor with STAGES carry-chunk stages.
// Ports: clk, rst, in_valid/in_ready, a, b, c_in, op ->
//   out_valid/out_ready, sum, carry, ovf, zero.
module pipelined_add_sub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int MSB   = WIDTH - 1;
    localparam int LAST  = STAGES - 1;

    // Stage k holds the operands, the carry into chunk k and the
    // sum chunks below k already resolved.
    logic [STAGES-1:0] pv;
    logic [WIDTH-1:0]  pa [STAGES];
    logic [WIDTH-1:0]  pb [STAGES];
    logic [WIDTH-1:0]  ps [STAGES];
    logic              pc [STAGES];

    logic [CHUNK:0]    t  [STAGES];
    logic [WIDTH-1:0]  ns [STAGES];

    logic              advance;
    logic              cin_eff;
    logic [WIDTH-1:0]  b_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = op[1] ? ~b : b;

    always_comb begin
        cin_eff = 1'b0;
        unique case (op)
            2'b00: cin_eff = 1'b0;
            2'b01: cin_eff = c_in;
            2'b10: cin_eff = 1'b1;
            2'b11: cin_eff = !c_in;
        endcase
    end

    // Each stage resolves its own chunk from the registered carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            t[k] = {1'b0, pa[k][k*CHUNK +: CHUNK]}
                 + {1'b0, pb[k][k*CHUNK +: CHUNK]}
                 + (CHUNK+1)'(pc[k]);
            ns[k] = ps[k];
            ns[k][k*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv        <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            pv[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                pv[k] <= pv[k-1];
            end
            out_valid <= pv[LAST];
            // Outputs only load on a real beat so bubbles leave them clean.
            if (pv[LAST]) begin
                sum   <= ns[LAST];
                carry <= t[LAST][CHUNK];
                ovf   <= (pa[LAST][MSB] == pb[LAST][MSB])
                      && (ns[LAST][MSB] != pa[LAST][MSB]);
                zero  <= ~|ns[LAST];
            end
        end
    end

    // Datapath skew registers; qualified by pv so they need no reset.
    always_ff @(posedge clk) begin
        if (advance) begin
            pa[0] <= a;
            pb[0] <= b_eff;
            pc[0] <= cin_eff;
            ps[0] <= '0;
            for (int k = 1; k < STAGES; k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
                pc[k] <= t[k-1][CHUNK];
                ps[k] <= ns[k-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=64, STAGES=4).
// Driver pushes expected results; a monitor pops on each out handshake.
module tb_pipelined_add_sub;

    localparam int W = 64;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
        logic         zero;
        int           acc_edge;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string info);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, info);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c,
                                input logic v, input logic z);
        exp_t e;
        e.sum = s; e.carry = c; e.ovf = v; e.zero = z;
        e.acc_edge = 0; e.lat = 1'b0;
        return e;
    endfunction

    // Reference for random beats, written from the operation definitions.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic [1:0] o);
        logic [W:0]   r;
        logic [W-1:0] ye;
        logic         ce;
        ye = o[1] ? ~y : y;
        case (o)
            2'b00: ce = 1'b0;
            2'b01: ce = ci;
            2'b10: ce = 1'b1;
            default: ce = !ci;
        endcase
        r = {1'b0, x} + {1'b0, ye} + (W+1)'(ce);
        return mk(r[W-1:0], r[W], (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]),
                  r[W-1:0] == '0);
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic [1:0] o,
                        input exp_t e, input bit lat);
        int n = 0;
        bit acc = 0;
        in_valid = 1'b1; a = x; b = y; c_in = ci; op = o;
        do begin
            #4;
            acc = in_ready;
            if (acc) begin
                e.acc_edge = cyc + 1;
                e.lat = lat;
                q.push_back(e);
            end
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) check("accept_timeout", 1'b0, "in_ready never rose");
        in_valid = 1'b0;
    endtask

    // Monitor: sample 1 time unit before each rising edge.
    exp_t         e_m;
    bit           prev_stall = 0;
    logic [W-1:0] s_sum;
    logic         s_c, s_v, s_z, s_ov;

    always @(negedge clk) begin
        #4;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold",
                      {out_valid, sum, carry, ovf, zero} == {s_ov, s_sum, s_c, s_v, s_z},
                      $sformatf("got v=%0b sum=%h required v=%0b sum=%h",
                                out_valid, sum, s_ov, s_sum));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready == 1'b0,
                      $sformatf("in_ready=%0b required 0", in_ready));
                prev_stall = 1;
                s_ov = out_valid; s_sum = sum; s_c = carry; s_v = ovf; s_z = zero;
            end else begin
                prev_stall = 0;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", 1'b0, $sformatf("sum=%h with empty queue", sum));
                end else begin
                    e_m = q.pop_front();
                    check("result",
                          {sum, carry, ovf, zero} == {e_m.sum, e_m.carry, e_m.ovf, e_m.zero},
                          $sformatf("got sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                                    sum, carry, ovf, zero,
                                    e_m.sum, e_m.carry, e_m.ovf, e_m.zero));
                    if (e_m.lat)
                        check("latency", (cyc - e_m.acc_edge) == S,
                              $sformatf("got %0d required %0d", cyc - e_m.acc_edge, S));
                end
            end
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0)
            check("drain_timeout", 1'b0, $sformatf("%0d beats missing", q.size()));
    endtask

    logic [W-1:0] ra, rb;
    logic         rc;
    logic [1:0]   ro;

    initial begin
        #2;
        check("reset_state",
              {out_valid, in_ready, sum, carry, ovf, zero} == {1'b0, 1'b1, 64'h0, 3'b000},
              $sformatf("got v=%0b rdy=%0b sum=%h c=%0b o=%0b z=%0b required 0 1 0 0 0 0",
                        out_valid, in_ready, sum, carry, ovf, zero));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, back to back, out_ready held high.
        send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 2'b00,
             mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0), 1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'b01,
             mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0), 1);
        send(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 2'b01,
             mk(64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0), 1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 2'b00,
             mk(64'h0, 1'b1, 1'b1, 1'b1), 1);
        send(64'h0, 64'h1, 1'b0, 2'b10,
             mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0), 1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 2'b10,
             mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0), 1);
        send(64'h5, 64'h3, 1'b1, 2'b11,
             mk(64'h1, 1'b1, 1'b0, 1'b0), 1);
        send(64'h3, 64'h3, 1'b0, 2'b11,
             mk(64'h0, 1'b1, 1'b0, 1'b1), 1);
        drain(50);

        // Backpressure: 10 random beats, stall cycles 3-7, then toggle.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = (i < 3) ? 1'b1 : (i <= 7) ? 1'b0 : (i % 2 == 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    rc = 1'($urandom);
                    ro = 2'($urandom);
                    send(ra, rb, rc, ro, model(ra, rb, rc, ro), 0);
                end
            end
        join
        drain(100);

        // Reset mid-operation with 3 beats in flight and one presented.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(64'(i + 10), 64'h1, 1'b0, 2'b00, mk(64'(i + 11), 1'b0, 1'b0, 1'b0), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_valid", out_valid == 1'b1,
              $sformatf("out_valid=%0b required 1", out_valid));
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid_op",
              {out_valid, in_ready, sum} == {1'b0, 1'b1, 64'h0},
              $sformatf("got v=%0b rdy=%0b sum=%h required 0 1 0", out_valid, in_ready, sum));
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("no_ghost_beats", out_valid == 1'b0,
              $sformatf("out_valid=%0b required 0", out_valid));
        send(64'h1234, 64'h0234, 1'b0, 2'b10, mk(64'h1000, 1'b1, 1'b0, 1'b0), 1);
        drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
